// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle control FSM.
// Opcodes, states, mux selects and extender modes.
package mc_control_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OPC   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_J,
    CLS_BEQ,
    CLS_ADDI,
    CLS_LOGIC,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_ILL
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode to instruction class and immediate-extension mode.
// Purely combinational.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_t       cls,
  output logic [1:0] ext
);

  always_comb begin
    cls = CLS_ILL;
    ext = EXT_SIGN;
    case (opcode)
      OP_R:    cls = CLS_R;
      OP_J:    cls = CLS_J;
      OP_BEQ:  cls = CLS_BEQ;
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_ANDI: begin
        cls = CLS_LOGIC;
        ext = EXT_ZERO;
      end
      OP_ORI: begin
        cls = CLS_LOGIC;
        ext = EXT_ZERO;
      end
      OP_LUI: begin
        cls = CLS_LUI;
        ext = EXT_UPPER;
      end
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: FETCH, DECODE, EXEC, MEM, WB.
// Outputs are combinational; enables are gated by rst.
module mc_control
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] signExtSignal,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     st_q, st_d;
  logic [5:0] op_q;
  logic [5:0] dec_op;
  cls_t       cls;
  logic [1:0] ext;

  logic pc_w, ir_w, m_rd, m_wr, rf_w, ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_FETCH;
      op_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) op_q <= opcode;
    end
  end

  // The IR is already valid in DECODE, before the opcode is latched.
  assign dec_op = (st_q == S_DECODE) ? opcode : op_q;

  mc_decode u_dec (
    .opcode (dec_op),
    .cls    (cls),
    .ext    (ext)
  );

  always_comb begin
    st_d          = S_FETCH;
    pc_w          = 1'b0;
    ir_w          = 1'b0;
    m_rd          = 1'b0;
    m_wr          = 1'b0;
    rf_w          = 1'b0;
    ill           = 1'b0;
    regDst        = 1'b0;
    memToReg      = 1'b0;
    aluSrcA       = 1'b0;
    aluSrcB       = SRCB_REG;
    signExtSignal = EXT_SIGN;
    aluOp         = ALU_ADD;
    pcSrc         = PC_ALU;
    case (st_q)
      S_FETCH: begin
        m_rd    = 1'b1;
        aluSrcB = SRCB_FOUR;
        ir_w    = memReady;
        pc_w    = memReady;
        st_d    = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM2;
        st_d    = S_EXEC;
        if (cls == CLS_J) begin
          pc_w  = 1'b1;
          pcSrc = PC_JMP;
          st_d  = S_FETCH;
        end else if (cls == CLS_ILL) begin
          ill   = 1'b1;
          st_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        case (cls)
          CLS_R: begin
            aluOp = ALU_FUNCT;
            st_d  = S_WB;
          end
          CLS_BEQ: begin
            aluOp = ALU_SUB;
            pcSrc = PC_OUT;
            pc_w  = zero;
          end
          CLS_LW, CLS_SW: begin
            aluSrcB       = SRCB_IMM;
            signExtSignal = ext;
            st_d          = S_MEM;
          end
          CLS_ADDI: begin
            aluSrcB       = SRCB_IMM;
            signExtSignal = ext;
            st_d          = S_WB;
          end
          CLS_LOGIC, CLS_LUI: begin
            aluSrcB       = SRCB_IMM;
            signExtSignal = ext;
            aluOp         = ALU_OPC;
            st_d          = S_WB;
          end
          default: st_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        m_rd = (cls == CLS_LW);
        m_wr = (cls == CLS_SW);
        if (!memReady)          st_d = S_MEM;
        else if (cls == CLS_LW) st_d = S_WB;
        else                    st_d = S_FETCH;
      end
      S_WB: begin
        rf_w     = 1'b1;
        regDst   = (cls == CLS_R);
        memToReg = (cls == CLS_LW);
      end
      default: st_d = S_FETCH;
    endcase
  end

  assign pcWrite  = pc_w & ~rst;
  assign irWrite  = ir_w & ~rst;
  assign memRead  = m_rd & ~rst;
  assign memWrite = m_wr & ~rst;
  assign regWrite = rf_w & ~rst;
  assign illegal  = ill  & ~rst;
  assign state    = st_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; opcodes, extension modes and state codes SHALL come from the shared defines.
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 opcode  in  6  instruction[31:26] from the external IR; valid from DECODE onward.
REQ-005 zero  in  1  ALU zero flag, used in EXEC for beq.
REQ-006 memReady  in  1  memory handshake; access completes in the cycle it is 1.
REQ-007 pcWrite  out  1  PC load enable.
REQ-008 irWrite  out  1  IR load enable.
REQ-009 memRead / memWrite  out  1 each  memory strobes.
REQ-010 regWrite  out  1  register-file write enable.
REQ-011 regDst, memToReg, aluSrcA  out  1 each  datapath mux selects.
REQ-012 aluSrcB  out  2  00 reg B, 01 const 4, 10 extended imm, 11 extended imm<<2.
REQ-013 signExtSignal  out  2  immediate-extender mode: 00 zero-ext, 01 sign-ext, 10 upper-16 (imm<<16).
REQ-014 aluOp  out  2  00 ADD, 01 SUB, 10 decode funct, 11 decode opcode.
REQ-015 pcSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-016 illegal  out  1  one-cycle pulse on an unsupported opcode.
REQ-017 state  out  3  current FSM state, for debug.

Function
REQ-018 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next clock.
REQ-019 Outputs SHALL be combinational from state, the latched opcode and the inputs; enables not listed for a state SHALL be 0.
REQ-020 FETCH: memRead=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00; irWrite=pcWrite=memReady; stay until memReady=1, then go to DECODE.
REQ-021 DECODE: latch opcode internally; aluSrcB=11, signExtSignal=01, aluOp=00 (branch-target precompute).
REQ-022 DECODE, j (0x02): pcWrite=1, pcSrc=10, go to FETCH.
REQ-023 DECODE, illegal opcode (outside 0x00,0x02,0x04,0x08,0x0C,0x0D,0x0F,0x23,0x2B): illegal=1, go to FETCH, no other enable.
REQ-024 DECODE, all other legal opcodes: go to EXEC.
REQ-025 EXEC, R-type (0x00): aluSrcA=1, aluSrcB=00, aluOp=10; go to WB.
REQ-026 EXEC, beq (0x04): aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcWrite=zero; go to FETCH.
REQ-027 EXEC, addi/lw/sw (0x08/0x23/0x2B): signExtSignal=01.
REQ-028 EXEC, andi/ori (0x0C/0x0D): signExtSignal=00.
REQ-029 EXEC, lui (0x0F): signExtSignal=10.
REQ-030 EXEC, all I-type: aluSrcA=1, aluSrcB=10; aluOp=00 for lw/sw/addi, 11 otherwise.
REQ-031 EXEC next state: lw/sw go to MEM; other I-type go to WB.
REQ-032 MEM: lw drives memRead=1, sw drives memWrite=1, held until memReady=1.
REQ-033 MEM on memReady=1: lw goes to WB, sw goes to FETCH; memReady=0 keeps MEM with strobes asserted.
REQ-034 WB: regWrite=1; regDst=1 only for R-type; memToReg=1 only for lw; go to FETCH.
REQ-035 signExtSignal SHALL be 01 in every state and case not named above.
REQ-036 Cycle counts with memReady held at 1: R/I-ALU 4, lw 5, sw 4, beq 3, j 2.

Reset
REQ-037 While rst=1: state=FETCH, latched opcode=0, all enables forced to 0 (pcWrite, irWrite, memRead, memWrite, regWrite), illegal=0.
REQ-038 rst asserted mid-operation SHALL drop in-flight strobes (e.g. memWrite in MEM) asynchronously, with no completion.
REQ-039 The first FETCH strobe SHALL appear in the first cycle after rst deasserts.

Structure
REQ-040 Shared defines header SHALL hold: opcode constants, state codes, aluOp/aluSrcB/pcSrc encodings, and extension modes 00/01/10 matching the immediate extender.
REQ-041 The block SHALL be one FSM module plus one combinational sub-module, mc_decode (latched opcode -> instruction class and extension mode).

Verification
REQ-042 Reset during MEM of sw with memReady=0 -> memWrite falls immediately; state=0 after release.
REQ-043 addi (0x08), memReady=1 -> states 0,1,2,4,0; signExtSignal=01 in EXEC; regWrite=1 in WB only.
REQ-044 lw with memReady low 3 cycles in MEM -> memRead held 4 cycles; then WB with memToReg=1.
REQ-045 ori (0x0D) then lui (0x0F) -> signExtSignal=00 in ori EXEC, 10 in lui EXEC; aluOp=11 in both.
REQ-046 beq with zero=1 vs zero=0 -> pcWrite=1, pcSrc=01 vs pcWrite=0; 3 cycles each.
REQ-047 Opcode 0x3F -> illegal pulses 1 cycle in DECODE; next state FETCH; no write enable asserted.
